seg_disp_arb: RTL

Two-source arbiter for the six-digit 74HC595 seven-segment display path. Each requester presents a complete display frame (20-bit BCD-range value, decimal-point mask, sign, enable) plus a request line. The block grants the shared `seg_595` display to one source at a time with round-robin fairness and a minimum hold time to prevent flicker. It drives the registered frame of the current owner into the downstream display driver. It sits between frame producers (e.g. `data_gen`, a key-set value source) and `seg_595_dynamic`.

---
 rtl/seg_disp_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg_disp_arb.sv
// Two-source round-robin arbiter for the shared six-digit seven-segment display.
// Grants one frame source at a time with a minimum hold and a one-cycle blanking gap on handover.
module seg_disp_arb #(
    parameter int               CNT_W    = 25,
    parameter logic [CNT_W-1:0] HOLD_MAX = 25'd24_999_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [1:0]  req,
    input  logic [19:0] data0,
    input  logic [19:0] data1,
    input  logic [5:0]  point0,
    input  logic [5:0]  point1,
    input  logic        sign0,
    input  logic        sign1,
    input  logic        seg_en0,
    input  logic        seg_en1,
    output logic [1:0]  gnt,
    output logic [19:0] data,
    output logic [5:0]  point,
    output logic        sign,
    output logic        seg_en,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OWN    = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [19:0]      data_q, data_d;
    logic [5:0]       point_q, point_d;
    logic             sign_q, sign_d;
    logic             seg_en_q, seg_en_d;

    logic owner;
    logic other;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    assign owner = gnt_q[1];
    assign other = ~gnt_q[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_OWN;
                    cnt_d   = '0;
                    // On a tie the source that did not own last time wins.
                    if (req == 2'b11) gnt_d = onehot(~last_q);
                    else              gnt_d = req;
                end
            end
            S_OWN: begin
                if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (req[other]) begin
                    state_d = S_SWITCH;
                    gnt_d   = 2'b00;
                    last_d  = owner;
                end else if (!req[owner]) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = owner;
                end
            end
            S_SWITCH: begin
                cnt_d = '0;
                if (req[~last_q]) begin
                    state_d = S_OWN;
                    gnt_d   = onehot(~last_q);
                end else if (req[last_q]) begin
                    state_d = S_OWN;
                    gnt_d   = onehot(last_q);
                end else begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame register follows the current grant; a blank frame while nobody owns.
    always_comb begin
        data_d   = '0;
        point_d  = '0;
        sign_d   = 1'b0;
        seg_en_d = 1'b0;
        if (gnt_q[0]) begin
            data_d   = data0;
            point_d  = point0;
            sign_d   = sign0;
            seg_en_d = seg_en0;
        end else if (gnt_q[1]) begin
            data_d   = data1;
            point_d  = point1;
            sign_d   = sign1;
            seg_en_d = seg_en1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            data_q   <= '0;
            point_q  <= '0;
            sign_q   <= 1'b0;
            seg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            point_q  <= point_d;
            sign_q   <= sign_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign gnt    = gnt_q;
    assign data   = data_q;
    assign point  = point_q;
    assign sign   = sign_q;
    assign seg_en = seg_en_q;
    assign busy   = (state_q == S_OWN);

endmodule
